// File: rtl/addr_seq_pkg.sv
// Shared types and constants for the address sequencer.
// Default field widths give an 8-bit {col,row} address.
package addr_seq_pkg;

  localparam int COLINDEXBITS_DFLT = 4;
  localparam int ROWINDEXBITS_DFLT = 4;
  localparam int ADDR_BITS         = COLINDEXBITS_DFLT + ROWINDEXBITS_DFLT;

  localparam logic MODE_LINEAR = 1'b0;
  localparam logic MODE_TABLE  = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/address_table.sv
// Programmable address table: synchronous write, combinational read, no reset.
// Contents are undefined until the host writes them.
module address_table
  import addr_seq_pkg::*;
#(
  parameter int AW         = ADDR_BITS,
  parameter int DEPTH      = 32,
  parameter int IDXBITS    = 5
) (
  input  logic               clk_i,
  input  logic               wr_en_i,
  input  logic [IDXBITS-1:0] wr_idx_i,
  input  logic [AW-1:0]      wr_dat_i,
  input  logic [IDXBITS-1:0] rd_idx_i,
  output logic [AW-1:0]      rd_dat_o
);

  logic [AW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_dat_i;
  end

  assign rd_dat_o = mem_q[rd_idx_i];

endmodule

// File: rtl/address_sequencer.sv
// Emits {col,row} addresses (linear sweep or table) over valid/ready; first valid 1 cycle after start,
// address/addrValid hold while storageReady=0. Optional multi-pass repeat under ADDR_SEQ_REPEAT_EN.
module address_sequencer
  import addr_seq_pkg::*;
#(
  parameter int COLINDEXBITS = 4,
  parameter int ROWINDEXBITS = 4,
  parameter int TABLEDEPTH   = 32,
  parameter int TABLEIDXBITS = 5
) (
  input  logic                                 clock,
  input  logic                                 resetN,
  input  logic                                 start,
  input  logic                                 mode,
  input  logic [COLINDEXBITS+ROWINDEXBITS-1:0] firstAddr,
  input  logic [COLINDEXBITS+ROWINDEXBITS-1:0] lastAddr,
  input  logic [TABLEIDXBITS:0]                tableLen,
  input  logic                                 tblWrEn,
  input  logic [TABLEIDXBITS-1:0]              tblWrIdx,
  input  logic [COLINDEXBITS+ROWINDEXBITS-1:0] tblWrData,
  input  logic                                 storageReady,
`ifdef ADDR_SEQ_REPEAT_EN
  input  logic [7:0]                           numPasses,
  output logic [7:0]                           passCount,
`endif
  output logic [COLINDEXBITS+ROWINDEXBITS-1:0] address,
  output logic                                 addrValid,
  output logic                                 busy,
  output logic                                 done
);

  localparam int AW = COLINDEXBITS + ROWINDEXBITS;
  localparam logic [TABLEIDXBITS:0]   DEPTH_L  = (TABLEIDXBITS+1)'(TABLEDEPTH);
  localparam logic [TABLEIDXBITS:0]   LEN_ONE  = (TABLEIDXBITS+1)'(1);
  localparam logic [TABLEIDXBITS-1:0] IDX_ONE  = TABLEIDXBITS'(1);
  localparam logic [AW-1:0]           ADDR_ONE = AW'(1);

  seq_state_t            state_q;
  logic                  mode_q, vld_q, busy_q, done_q;
  logic [AW-1:0]         addr_q, last_q;
  logic [TABLEIDXBITS:0] len_q;
  logic [TABLEIDXBITS-1:0] idx_q;

  logic                    xfer, last_beat, last_pass, wrap, tbl_wr;
  logic [TABLEIDXBITS:0]   len_d;
  logic [TABLEIDXBITS-1:0] rd_idx;
  logic [AW-1:0]           rd_dat, rd_fwd, addr_d;

`ifdef ADDR_SEQ_REPEAT_EN
  logic [AW-1:0] first_q;
  logic [7:0]    npass_q, pass_q;
`endif

  always_comb begin
    len_d     = (tableLen > DEPTH_L) ? DEPTH_L : tableLen;
    xfer      = vld_q && storageReady;
    last_beat = (mode_q == MODE_TABLE) ? ({1'b0, idx_q} == len_q - LEN_ONE)
                                       : (addr_q == last_q);
`ifdef ADDR_SEQ_REPEAT_EN
    last_pass = (pass_q + 8'd1) >= npass_q;
`else
    last_pass = 1'b1;
`endif
    wrap   = last_beat && !last_pass;
    rd_idx = (state_q == IDLE || wrap) ? '0 : idx_q + IDX_ONE;
    // A table write landing with start must be visible to the first read.
    rd_fwd = (state_q == IDLE && tblWrEn && tblWrIdx == '0) ? tblWrData : rd_dat;
    tbl_wr = tblWrEn && (state_q == IDLE);
    if (mode_q == MODE_TABLE) addr_d = rd_fwd;
`ifdef ADDR_SEQ_REPEAT_EN
    else if (wrap)            addr_d = first_q;
`endif
    else                      addr_d = addr_q + ADDR_ONE;
  end

  address_table #(
    .AW      (AW),
    .DEPTH   (TABLEDEPTH),
    .IDXBITS (TABLEIDXBITS)
  ) u_table (
    .clk_i    (clock),
    .wr_en_i  (tbl_wr),
    .wr_idx_i (tblWrIdx),
    .wr_dat_i (tblWrData),
    .rd_idx_i (rd_idx),
    .rd_dat_o (rd_dat)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      mode_q  <= MODE_LINEAR;
      addr_q  <= '0;
      last_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ADDR_SEQ_REPEAT_EN
      first_q <= '0;
      npass_q <= 8'd1;
      pass_q  <= 8'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            last_q <= lastAddr;
            len_q  <= len_d;
            idx_q  <= '0;
`ifdef ADDR_SEQ_REPEAT_EN
            first_q <= firstAddr;
            npass_q <= (numPasses == 8'd0) ? 8'd1 : numPasses;
            pass_q  <= 8'd0;
`endif
            if (mode == MODE_TABLE && len_d == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= RUN;
              vld_q   <= 1'b1;
              busy_q  <= 1'b1;
              addr_q  <= (mode == MODE_TABLE) ? rd_fwd : firstAddr;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            if (last_beat && last_pass) begin
              state_q <= IDLE;
              vld_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              addr_q <= addr_d;
              idx_q  <= wrap ? '0 : idx_q + IDX_ONE;
`ifdef ADDR_SEQ_REPEAT_EN
              if (wrap) pass_q <= pass_q + 8'd1;
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign address   = addr_q;
  assign addrValid = vld_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef ADDR_SEQ_REPEAT_EN
  assign passCount = pass_q;
`endif

endmodule

// File: tb/tb_address_sequencer.sv
// Bench for address_sequencer: vector table, hand sequences and random runs vs a queue-based model.
module tb_address_sequencer;

  logic       clock, resetN, start, mode, tblWrEn, storageReady;
  logic [7:0] firstAddr, lastAddr, tblWrData, address;
  logic [5:0] tableLen;
  logic [4:0] tblWrIdx;
  logic       addrValid, busy, done;
`ifdef ADDR_SEQ_REPEAT_EN
  logic [7:0] numPasses, passCount;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] tbl_m [32];

  address_sequencer dut (
    .clock(clock), .resetN(resetN), .start(start), .mode(mode),
    .firstAddr(firstAddr), .lastAddr(lastAddr), .tableLen(tableLen),
    .tblWrEn(tblWrEn), .tblWrIdx(tblWrIdx), .tblWrData(tblWrData),
    .storageReady(storageReady),
`ifdef ADDR_SEQ_REPEAT_EN
    .numPasses(numPasses), .passCount(passCount),
`endif
    .address(address), .addrValid(addrValid), .busy(busy), .done(done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic write_tbl(input logic [4:0] idx, input logic [7:0] dat);
    @(negedge clock);
    tblWrEn = 1'b1; tblWrIdx = idx; tblWrData = dat;
    tbl_m[idx] = dat;
    @(negedge clock);
    tblWrEn = 1'b0;
  endtask

  // Runs one sequence; expected stream is built from the rules, then every cycle is checked.
  task automatic run_seq(input logic m, input logic [7:0] fa, input logic [7:0] la,
                         input logic [5:0] len, input int rdy, input logic [7:0] np,
                         input bit inject, input bit wr0, input logic [7:0] wr0_dat,
                         output int n_xfer, output logic [7:0] f_seen, output logic [7:0] l_seen);
    logic [7:0] q[$];
    int pq[$];
    int passes, eff;
    logic [7:0] a;
    bit fin, ok, r;
    passes = 1;
`ifdef ADDR_SEQ_REPEAT_EN
    passes = (np == 8'd0) ? 1 : int'(np);
`endif
    if (wr0) tbl_m[0] = wr0_dat;
    for (int p = 0; p < passes; p++) begin
      if (m == 1'b0) begin
        a = fa;
        while (1) begin
          q.push_back(a); pq.push_back(p);
          if (a == la) break;
          a = a + 8'd1;
        end
      end else begin
        eff = (int'(len) > 32) ? 32 : int'(len);
        for (int i = 0; i < eff; i++) begin
          q.push_back(tbl_m[i]); pq.push_back(p);
        end
      end
    end
    @(negedge clock);
    mode = m; firstAddr = fa; lastAddr = la; tableLen = len; start = 1'b1;
`ifdef ADDR_SEQ_REPEAT_EN
    numPasses = np;
`endif
    if (wr0) begin tblWrEn = 1'b1; tblWrIdx = 5'd0; tblWrData = wr0_dat; end
    @(negedge clock);
    start = 1'b0; tblWrEn = 1'b0;
    firstAddr = 8'($urandom); lastAddr = 8'($urandom); tableLen = 6'($urandom); mode = ~m;
    n_xfer = 0; f_seen = 8'h00; l_seen = 8'h00;
    if (q.size() == 0) begin
      check("empty_done", done, 1);
      check("empty_vld", addrValid, 0);
      check("empty_busy", busy, 0);
      @(negedge clock);
      check("empty_done_pulse", done, 0);
      return;
    end
    fin = 0; ok = 0;
    for (int c = 0; c < 3000; c++) begin
      if (fin) begin
        check("done", done, 1);
        check("done_vld", addrValid, 0);
        check("done_busy", busy, 0);
        check("addr_retain", address, q[q.size()-1]);
        ok = 1;
        break;
      end
      check("no_early_done", done, 0);
      check("vld", addrValid, 1);
      check("busy", busy, 1);
      check("addr", address, q[n_xfer]);
`ifdef ADDR_SEQ_REPEAT_EN
      check("passCount", passCount, pq[n_xfer]);
`endif
      case (rdy)
        0:       r = 1'b1;
        1:       r = (c % 2 == 0);
        default: r = ($urandom_range(0, 2) != 0);
      endcase
      storageReady = r;
      if (inject && $urandom_range(0, 3) == 0) begin
        start = 1'b1; tblWrEn = 1'b1; tblWrIdx = 5'($urandom); tblWrData = 8'($urandom);
      end else begin
        start = 1'b0; tblWrEn = 1'b0;
      end
      if (r) begin
        if (n_xfer == 0) f_seen = address;
        l_seen = address;
        n_xfer++;
        if (n_xfer == q.size()) fin = 1;
      end
      @(negedge clock);
    end
    start = 1'b0; tblWrEn = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL timeout: got %0d transfers expected %0d", n_xfer, q.size());
    end
    @(negedge clock);
    check("done_one_cycle", done, 0);
  endtask

  typedef struct {
    logic       m;
    logic [7:0] fa, la;
    logic [5:0] len;
    int         rdy;
    int         cnt;
    logic [7:0] first, last;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int n;
    logic [7:0] f, l;
    logic [7:0] init4 [4];
    vecs[0] = '{1'b0, 8'h00, 8'h03, 6'd0,  0, 4,   8'h00, 8'h03};
    vecs[1] = '{1'b0, 8'hFE, 8'h01, 6'd0,  0, 4,   8'hFE, 8'h01};
    vecs[2] = '{1'b1, 8'h00, 8'h00, 6'd4,  1, 4,   8'h84, 8'h58};
    vecs[3] = '{1'b1, 8'h00, 8'h00, 6'd0,  0, 0,   8'h00, 8'h00};
    vecs[4] = '{1'b0, 8'h55, 8'h55, 6'd0,  1, 1,   8'h55, 8'h55};
    vecs[5] = '{1'b0, 8'h00, 8'hFF, 6'd0,  2, 256, 8'h00, 8'hFF};
    vecs[6] = '{1'b1, 8'h00, 8'h00, 6'd40, 2, 32,  8'h84, 8'hBA};
    vecs[7] = '{1'b0, 8'hFF, 8'h00, 6'd0,  1, 2,   8'hFF, 8'h00};
    init4[0] = 8'h84; init4[1] = 8'h83; init4[2] = 8'h88; init4[3] = 8'h58;

    resetN = 1'b1; start = 1'b0; mode = 1'b0; firstAddr = 8'h00; lastAddr = 8'h00;
    tableLen = 6'd0; tblWrEn = 1'b0; tblWrIdx = 5'd0; tblWrData = 8'h00; storageReady = 1'b1;
`ifdef ADDR_SEQ_REPEAT_EN
    numPasses = 8'd1;
`endif
    #2 resetN = 1'b0;
    #1;
    check("rst_addr", address, 0);
    check("rst_vld", addrValid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clock);
    @(negedge clock);
    resetN = 1'b1;

    for (int i = 0; i < 32; i++)
      write_tbl(5'(i), (i < 4) ? init4[i] : (8'(i) ^ 8'hA5));

    for (int i = 0; i < 8; i++) begin
      run_seq(vecs[i].m, vecs[i].fa, vecs[i].la, vecs[i].len, vecs[i].rdy, 8'd1,
              0, 0, 8'h00, n, f, l);
      check($sformatf("vec%0d_cnt", i), n, vecs[i].cnt);
      if (vecs[i].cnt > 0) begin
        check($sformatf("vec%0d_first", i), f, vecs[i].first);
        check($sformatf("vec%0d_last", i), l, vecs[i].last);
      end
    end

    // Table write coinciding with start is seen by the first read.
    run_seq(1'b1, 8'h00, 8'h00, 6'd2, 0, 8'd1, 0, 1, 8'h77, n, f, l);
    check("wr_with_start_first", f, 8'h77);

    // Reset mid-run after two transfers aborts without done; restart replays from the top.
    @(negedge clock);
    mode = 1'b0; firstAddr = 8'h20; lastAddr = 8'h2F; start = 1'b1; storageReady = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("pre_rst_addr", address, 8'h22);
    resetN = 1'b0;
    #1;
    check("abort_vld", addrValid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clock);
    resetN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("abort_no_done", done, 0);
    end
    run_seq(1'b0, 8'h20, 8'h2F, 6'd0, 0, 8'd1, 0, 0, 8'h00, n, f, l);
    check("replay_first", f, 8'h20);
    check("replay_cnt", n, 16);

`ifdef ADDR_SEQ_REPEAT_EN
    run_seq(1'b0, 8'h10, 8'h11, 6'd0, 0, 8'd3, 0, 0, 8'h00, n, f, l);
    check("repeat_cnt", n, 6);
    run_seq(1'b1, 8'h00, 8'h00, 6'd3, 2, 8'd0, 0, 0, 8'h00, n, f, l);
    check("repeat_np0_cnt", n, 3);
`endif

    for (int it = 0; it < 25; it++) begin
      logic [7:0] fa, la;
      for (int w = 0; w < 3; w++) write_tbl(5'($urandom), 8'($urandom));
      fa = 8'($urandom);
      la = ($urandom_range(0, 3) == 0) ? 8'($urandom) : fa + 8'($urandom_range(0, 12));
      run_seq(1'($urandom_range(0, 1)), fa, la, 6'($urandom_range(0, 40)), 2,
              8'($urandom_range(0, 3)), 1, ($urandom_range(0, 4) == 0), 8'($urandom), n, f, l);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/address_sequencer.md
Name: address_sequencer

Overview:
- Parametrised successor to the single-pass address counter that feeds the hit-count memory write path.
- Emits a stream of {col,row} addresses in one of two modes: a linear sweep over a programmable range, or a programmable address table.
- Uses a valid/ready handshake with the downstream storage block.
- Supports start/done control, so the host can rerun sequences without reset and needs no dummy leading entries.

Parameters:
- COLINDEXBITS, 4, column field width (address MSBs)
- ROWINDEXBITS, 4, row field width (address LSBs)
- TABLEDEPTH, 32, number of entries in the programmable address table
- TABLEIDXBITS, 5, table index width (clog2 of TABLEDEPTH)

Ports:
- clock  in  1  system clock, rising edge
- resetN  in  1  asynchronous active-low reset
- start  in  1  begin a sequence; sampled only in IDLE
- mode  in  1  0 = linear sweep, 1 = table; latched on accepted start
- firstAddr  in  COLINDEXBITS+ROWINDEXBITS  linear start address; latched on start
- lastAddr  in  COLINDEXBITS+ROWINDEXBITS  linear end address, inclusive; latched on start
- tableLen  in  TABLEIDXBITS+1  number of table entries to emit; latched on start
- tblWrEn  in  1  table write strobe
- tblWrIdx  in  TABLEIDXBITS  table write index
- tblWrData  in  COLINDEXBITS+ROWINDEXBITS  table write data
- storageReady  in  1  downstream ready
- address  out  COLINDEXBITS+ROWINDEXBITS  current address, registered
- addrValid  out  1  address is valid
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset (async, resetN=0):
  - state=IDLE; address=0, addrValid=0, busy=0, done=0.
  - Table contents are not reset; they are undefined after power-up.
  - Reset mid-sequence aborts immediately; no done pulse is produced.
- States: IDLE, RUN.
- IDLE, start=1:
  - Latch mode, firstAddr, lastAddr, tableLen.
  - Next cycle: state=RUN, busy=1, addrValid=1, address = firstAddr (linear) or table[0] (table). Latency from start to first valid is 1 cycle.
- IDLE, table mode with tableLen=0, or tableLen>TABLEDEPTH clamped to TABLEDEPTH:
  - tableLen=0: no RUN; done pulses the cycle after start; addrValid stays 0.
- RUN handshake:
  - Transfer occurs on addrValid && storageReady.
  - address and addrValid hold stable while storageReady=0.
  - On a non-final transfer, the next address appears the following cycle with addrValid still 1. This gives one address per cycle when storageReady is held high.
- Linear sequencing:
  - Next address = address+1, modulo 2^(COLINDEXBITS+ROWINDEXBITS).
  - The final address is lastAddr.
  - If firstAddr>lastAddr, the sequence wraps through all-ones to 0, then continues to lastAddr.
  - If firstAddr==lastAddr, exactly one address is emitted.
- Table sequencing:
  - Internal index runs 0..tableLen-1, read combinationally from the table.
  - The final transfer is at index tableLen-1.
- Final transfer: next cycle addrValid=0, busy=0, done=1 for one cycle, state=IDLE. address retains its last value.
- start while in RUN is ignored.
- Table writes:
  - Accepted only in IDLE; tblWrEn in RUN is ignored.
  - A write in the same cycle as an accepted start is applied. The sequence reads the new value.

Optional Feature:
- Macro: ADDR_SEQ_REPEAT_EN.
- With the macro: adds input numPasses [7:0], latched on start.
  - The full sequence is emitted numPasses times back to back, with no bubble between passes. numPasses=0 is treated as 1.
  - done pulses only after the last pass.
  - Adds output passCount [7:0]: 0 during the first pass, incremented on each pass wrap, reset to 0 on start.
- Without the macro: single pass; no numPasses or passCount ports.

Decomposition:
- Package addr_seq_pkg:
  - ADDR_BITS = COLINDEXBITS+ROWINDEXBITS.
  - Mode constants MODE_LINEAR=0, MODE_TABLE=1.
  - State encoding IDLE/RUN.
- Sub-module address_table:
  - TABLEDEPTH x ADDR_BITS register array.
  - Synchronous write port, combinational read port.
  - No reset.
- The sequencer FSM, index counter and output registers stay in address_sequencer.

Test Plan:
- Linear, firstAddr=0x00, lastAddr=0x03, storageReady=1 -> addrValid high for 4 cycles, addresses 0x00,0x01,0x02,0x03; done pulses the cycle after 0x03; busy low with it.
- Linear wrap, firstAddr=0xFE, lastAddr=0x01 -> addresses 0xFE,0xFF,0x00,0x01, then done.
- Table, entries {0x84,0x83,0x88,0x58}, tableLen=4, storageReady toggling 1,0,1,0 -> each address held while ready=0; exactly 4 transfers in order; no leading dummy entries.
- Table, tableLen=0 -> addrValid never asserts; done pulses one cycle after start.
- resetN asserted low mid-RUN after 2 transfers -> addrValid=0 and busy=0 immediately; no done. A new start replays from the first address.
- With ADDR_SEQ_REPEAT_EN, linear 0x10..0x11, numPasses=3 -> sequence 0x10,0x11,0x10,0x11,0x10,0x11; passCount 0,0,1,1,2,2; single done pulse at the end.
